// File: rtl/e203_itcm_icb_slv.sv
// e203_itcm_icb_slv
// ICB responder in front of the ITCM single-port SRAM (1-cycle read latency).
// Holds at most one outstanding transaction; responses come back in order,
// one cycle after the command handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   icb_cmd_*         ICB command channel (valid/ready/addr/read/wdata/wmask)
//   icb_rsp_*         ICB response channel (valid/ready/err/rdata)
//   sram_*            SRAM strobes, driven combinationally in the handshake cycle
//   itcm_holdup       SRAM output still holds the last read word
//
// Optional feature: define E203_ITCM_HOLDUP_EN to implement itcm_holdup;
// otherwise it is tied to 0 and no register exists for it.

module e203_itcm_icb_slv #(
   parameter int unsigned AW  = 16,
   parameter int unsigned DW  = 32,
   parameter int unsigned SAW = AW - 2
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              icb_cmd_valid,
   output logic              icb_cmd_ready,
   input  logic [AW-1:0]     icb_cmd_addr,
   input  logic              icb_cmd_read,
   input  logic [DW-1:0]     icb_cmd_wdata,
   input  logic [DW/8-1:0]   icb_cmd_wmask,

   output logic              icb_rsp_valid,
   input  logic              icb_rsp_ready,
   output logic              icb_rsp_err,
   output logic [DW-1:0]     icb_rsp_rdata,

   output logic              sram_cs,
   output logic              sram_we,
   output logic [SAW-1:0]    sram_addr,
   output logic [DW/8-1:0]   sram_wem,
   output logic [DW-1:0]     sram_din,
   input  logic [DW-1:0]     sram_dout,

   output logic              itcm_holdup
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RSP  = 1'b1
   } state_t;

   state_t state_q, state_d;
   logic   rsp_is_read_q, rsp_is_read_d;
   logic   rsp_err_q, rsp_err_d;

   logic   misaligned;
   logic   cmd_hsk;
   logic   rsp_hsk;

   // Handshake decode and next-state / per-transaction flag capture
   always_comb begin
      state_d       = state_q;
      rsp_is_read_d = rsp_is_read_q;
      rsp_err_d     = rsp_err_q;

      misaligned    = |icb_cmd_addr[1:0];
      icb_cmd_ready = (state_q == ST_IDLE) | icb_rsp_ready;
      cmd_hsk       = icb_cmd_valid & icb_cmd_ready;
      rsp_hsk       = (state_q == ST_RSP) & icb_rsp_ready;

      // A new command always wins over a concurrent response retirement
      if (cmd_hsk) begin
         state_d       = ST_RSP;
         rsp_is_read_d = icb_cmd_read & ~misaligned;
         rsp_err_d     = misaligned;
      end else if (rsp_hsk) begin
         state_d       = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         rsp_is_read_q <= 1'b0;
         rsp_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         rsp_is_read_q <= rsp_is_read_d;
         rsp_err_q     <= rsp_err_d;
      end
   end

   // SRAM strobes: no access for misaligned commands; no access while stalled
   // so sram_dout stays stable under back-pressure
   always_comb begin
      sram_cs   = cmd_hsk & ~misaligned;
      sram_we   = ~icb_cmd_read;
      sram_addr = SAW'(icb_cmd_addr[AW-1:2]);
      sram_wem  = icb_cmd_wmask;
      sram_din  = icb_cmd_wdata;
   end

   // Response channel
   always_comb begin
      icb_rsp_valid = (state_q == ST_RSP);
      icb_rsp_err   = rsp_err_q;
      icb_rsp_rdata = rsp_is_read_q ? sram_dout : DW'(0);
   end

`ifdef E203_ITCM_HOLDUP_EN
   logic holdup_q, holdup_d;

   // Any accepted command reloads the flag: aligned reads set it, writes and
   // errored commands clear it; otherwise the SRAM output is untouched
   always_comb begin
      holdup_d = holdup_q;
      if (cmd_hsk) begin
         holdup_d = icb_cmd_read & ~misaligned;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         holdup_q <= 1'b0;
      end else begin
         holdup_q <= holdup_d;
      end
   end

   assign itcm_holdup = holdup_q;
`else
   assign itcm_holdup = 1'b0;
`endif

endmodule

// File: tb/tb_e203_itcm_icb_slv.sv
// Directed testbench for e203_itcm_icb_slv with a behavioural 1-cycle SRAM.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 3 time units after the rising edge.

module tb_e203_itcm_icb_slv;

   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 32;
   localparam int unsigned SAW = AW - 2;
   localparam int unsigned MW  = DW / 8;

`ifdef E203_ITCM_HOLDUP_EN
   localparam logic HOLD_EN = 1'b1;
`else
   localparam logic HOLD_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            icb_cmd_valid;
   logic            icb_cmd_ready;
   logic [AW-1:0]   icb_cmd_addr;
   logic            icb_cmd_read;
   logic [DW-1:0]   icb_cmd_wdata;
   logic [MW-1:0]   icb_cmd_wmask;
   logic            icb_rsp_valid;
   logic            icb_rsp_ready;
   logic            icb_rsp_err;
   logic [DW-1:0]   icb_rsp_rdata;
   logic            sram_cs;
   logic            sram_we;
   logic [SAW-1:0]  sram_addr;
   logic [MW-1:0]   sram_wem;
   logic [DW-1:0]   sram_din;
   logic [DW-1:0]   sram_dout;
   logic            itcm_holdup;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem [0:255];

   e203_itcm_icb_slv #(.AW(AW), .DW(DW), .SAW(SAW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .icb_cmd_valid (icb_cmd_valid),
      .icb_cmd_ready (icb_cmd_ready),
      .icb_cmd_addr  (icb_cmd_addr),
      .icb_cmd_read  (icb_cmd_read),
      .icb_cmd_wdata (icb_cmd_wdata),
      .icb_cmd_wmask (icb_cmd_wmask),
      .icb_rsp_valid (icb_rsp_valid),
      .icb_rsp_ready (icb_rsp_ready),
      .icb_rsp_err   (icb_rsp_err),
      .icb_rsp_rdata (icb_rsp_rdata),
      .sram_cs       (sram_cs),
      .sram_we       (sram_we),
      .sram_addr     (sram_addr),
      .sram_wem      (sram_wem),
      .sram_din      (sram_din),
      .sram_dout     (sram_dout),
      .itcm_holdup   (itcm_holdup)
   );

   always #5 clk = ~clk;

   // Behavioural single-port SRAM, 1-cycle read latency, byte-masked writes
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we) begin
            for (int b = 0; b < int'(MW); b++) begin
               if (sram_wem[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_din[b*8 +: 8];
            end
         end else begin
            sram_dout <= mem[sram_addr[7:0]];
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic [AW-1:0] addr, input logic rd,
                            input logic [DW-1:0] wd, input logic [MW-1:0] wm);
      icb_cmd_valid = 1'b1;
      icb_cmd_addr  = addr;
      icb_cmd_read  = rd;
      icb_cmd_wdata = wd;
      icb_cmd_wmask = wm;
   endtask

   task automatic test_reset();
      #2;
      if (icb_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", icb_cmd_ready); end
      total++;
      if (icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", icb_rsp_valid); end
      total++;
      if (icb_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", icb_rsp_err); end
      total++;
      if (icb_rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", icb_rsp_rdata); end
      total++;
      if (sram_cs !== 1'b0) begin bad++; $display("FAIL reset_sram_cs got=%b exp=0", sram_cs); end
      total++;
      if (itcm_holdup !== 1'b0) begin bad++; $display("FAIL reset_holdup got=%b exp=0", itcm_holdup); end
      total++;
   endtask

   task automatic test_single_read();
      next_cycle();
      drive_cmd(16'h0010, 1'b1, 32'h0, 4'h0);
      icb_rsp_ready = 1'b1;
      #2;
      if (sram_cs !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 14'h0004) begin
         bad++; $display("FAIL single_sram cs=%b we=%b addr=%h exp cs=1 we=0 addr=0004", sram_cs, sram_we, sram_addr);
      end
      total++;
      next_cycle();
      icb_cmd_valid = 1'b0;
      #2;
      if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'hDEADBEEF || icb_rsp_err !== 1'b0) begin
         bad++; $display("FAIL single_rsp valid=%b rdata=%h err=%b exp 1/deadbeef/0", icb_rsp_valid, icb_rsp_rdata, icb_rsp_err);
      end
      total++;
      next_cycle();
      #2;
      if (icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL single_retire valid=%b exp=0", icb_rsp_valid); end
      total++;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_d [0:2];
      exp_d[0] = 32'h11111111;
      exp_d[1] = 32'h22222222;
      exp_d[2] = 32'h33333333;
      icb_rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         if (i < 3) drive_cmd(AW'(i * 4), 1'b1, 32'h0, 4'h0);
         else       icb_cmd_valid = 1'b0;
         #2;
         if (i < 3) begin
            if (icb_cmd_ready !== 1'b1 || sram_cs !== 1'b1) begin
               bad++; $display("FAIL b2b_accept_%0d ready=%b cs=%b exp 1/1", i, icb_cmd_ready, sram_cs);
            end
            total++;
         end
         if (i > 0) begin
            if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== exp_d[i-1]) begin
               bad++; $display("FAIL b2b_rsp_%0d valid=%b rdata=%h exp 1/%h", i - 1, icb_rsp_valid, icb_rsp_rdata, exp_d[i-1]);
            end
            total++;
         end
      end
      next_cycle();
      #2;
      if (icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_retire valid=%b exp=0", icb_rsp_valid); end
      total++;
   endtask

   task automatic test_backpressure();
      next_cycle();
      drive_cmd(16'h0020, 1'b1, 32'h0, 4'h0);
      icb_rsp_ready = 1'b1;
      next_cycle();
      drive_cmd(16'h0000, 1'b1, 32'h0, 4'h0);
      icb_rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) next_cycle();
         #2;
         if (icb_rsp_valid !== 1'b1 || icb_cmd_ready !== 1'b0 || sram_cs !== 1'b0 ||
             icb_rsp_rdata !== 32'h20202020) begin
            bad++; $display("FAIL bp_stall_%0d valid=%b ready=%b cs=%b rdata=%h exp 1/0/0/20202020",
                            i, icb_rsp_valid, icb_cmd_ready, sram_cs, icb_rsp_rdata);
         end
         total++;
      end
      next_cycle();
      icb_rsp_ready = 1'b1;
      #2;
      if (icb_cmd_ready !== 1'b1 || sram_cs !== 1'b1 || icb_rsp_rdata !== 32'h20202020) begin
         bad++; $display("FAIL bp_release ready=%b cs=%b rdata=%h exp 1/1/20202020", icb_cmd_ready, sram_cs, icb_rsp_rdata);
      end
      total++;
      next_cycle();
      icb_cmd_valid = 1'b0;
      #2;
      if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'h11111111) begin
         bad++; $display("FAIL bp_next_rsp valid=%b rdata=%h exp 1/11111111", icb_rsp_valid, icb_rsp_rdata);
      end
      total++;
      next_cycle();
   endtask

   task automatic test_misaligned();
      next_cycle();
      drive_cmd(16'h0013, 1'b1, 32'h0, 4'h0);
      icb_rsp_ready = 1'b1;
      #2;
      if (sram_cs !== 1'b0 || icb_cmd_ready !== 1'b1) begin
         bad++; $display("FAIL misal_cmd cs=%b ready=%b exp 0/1", sram_cs, icb_cmd_ready);
      end
      total++;
      next_cycle();
      icb_cmd_valid = 1'b0;
      #2;
      if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b1 || icb_rsp_rdata !== 32'h0) begin
         bad++; $display("FAIL misal_rsp valid=%b err=%b rdata=%h exp 1/1/0", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
      end
      total++;
      next_cycle();
   endtask

   task automatic test_write_read();
      next_cycle();
      drive_cmd(16'h0040, 1'b0, 32'hA5A5A5A5, 4'b0011);
      icb_rsp_ready = 1'b1;
      #2;
      if (sram_cs !== 1'b1 || sram_we !== 1'b1 || sram_wem !== 4'b0011 ||
          sram_din !== 32'hA5A5A5A5 || sram_addr !== 14'h0010) begin
         bad++; $display("FAIL wr_sram cs=%b we=%b wem=%b din=%h addr=%h exp 1/1/0011/a5a5a5a5/0010",
                         sram_cs, sram_we, sram_wem, sram_din, sram_addr);
      end
      total++;
      next_cycle();
      drive_cmd(16'h0040, 1'b1, 32'h0, 4'h0);
      #2;
      if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b0 || icb_rsp_rdata !== 32'h0) begin
         bad++; $display("FAIL wr_rsp valid=%b err=%b rdata=%h exp 1/0/0", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
      end
      total++;
      next_cycle();
      icb_cmd_valid = 1'b0;
      #2;
      if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'hFFFFA5A5) begin
         bad++; $display("FAIL rd_after_wr valid=%b rdata=%h exp 1/ffffa5a5", icb_rsp_valid, icb_rsp_rdata);
      end
      total++;
      next_cycle();
   endtask

   task automatic test_holdup_reset();
      next_cycle();
      drive_cmd(16'h0008, 1'b1, 32'h0, 4'h0);
      icb_rsp_ready = 1'b1;
      next_cycle();
      icb_cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) next_cycle();
         #2;
         if (itcm_holdup !== HOLD_EN) begin
            bad++; $display("FAIL holdup_idle_%0d got=%b exp=%b", i, itcm_holdup, HOLD_EN);
         end
         total++;
      end
      next_cycle();
      drive_cmd(16'h0044, 1'b0, 32'h0, 4'h0);
      next_cycle();
      icb_cmd_valid = 1'b0;
      #2;
      if (itcm_holdup !== 1'b0) begin bad++; $display("FAIL holdup_wr_clear got=%b exp=0", itcm_holdup); end
      total++;
      // Park a read response under back-pressure, then reset asynchronously
      next_cycle();
      drive_cmd(16'h0008, 1'b1, 32'h0, 4'h0);
      next_cycle();
      icb_cmd_valid = 1'b0;
      icb_rsp_ready = 1'b0;
      #2;
      if (icb_rsp_valid !== 1'b1 || itcm_holdup !== HOLD_EN || icb_rsp_rdata !== 32'h33333333) begin
         bad++; $display("FAIL pre_reset valid=%b holdup=%b rdata=%h exp 1/%b/33333333",
                         icb_rsp_valid, itcm_holdup, icb_rsp_rdata, HOLD_EN);
      end
      total++;
      rst_n = 1'b0;
      #1;
      if (icb_rsp_valid !== 1'b0 || itcm_holdup !== 1'b0 || icb_cmd_ready !== 1'b1 || icb_rsp_rdata !== 32'h0) begin
         bad++; $display("FAIL async_reset valid=%b holdup=%b ready=%b rdata=%h exp 0/0/1/0",
                         icb_rsp_valid, itcm_holdup, icb_cmd_ready, icb_rsp_rdata);
      end
      total++;
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      #2;
      if (icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL post_reset valid=%b exp=0", icb_rsp_valid); end
      total++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]  = 32'h11111111;
      mem[1]  = 32'h22222222;
      mem[2]  = 32'h33333333;
      mem[4]  = 32'hDEADBEEF;
      mem[8]  = 32'h20202020;
      mem[16] = 32'hFFFF0000;
      sram_dout     = 32'h0;
      rst_n         = 1'b0;
      icb_cmd_valid = 1'b0;
      icb_cmd_addr  = '0;
      icb_cmd_read  = 1'b0;
      icb_cmd_wdata = '0;
      icb_cmd_wmask = '0;
      icb_rsp_ready = 1'b1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_single_read();
      test_back_to_back();
      test_backpressure();
      test_misaligned();
      test_write_read();
      test_holdup_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
